outbuf_cntl: RTL and testbench

Output buffer controller for the erasure-coding accelerator. It collects encoded packet beats from the engine, packs them into full-width lines in a two-entry ping-pong line buffer, and writes each line to the output buffer memory at consecutive addresses. It is the write-side counterpart of the input buffer controller and sits between the engine output and the output buffer memory.

---
 rtl/outbuf_cntl_pkg.sv | 11 +
 rtl/outbuf_cntl_if.sv | 29 ++
 rtl/outbuf_line_pingpong.sv | 58 +++++
 rtl/outbuf_cntl.sv | 55 +++++
 tb/tb_outbuf_cntl.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/outbuf_cntl_pkg.sv
// outbuf_cntl_pkg: shared widths and FSM state type for the output buffer controller
package outbuf_cntl_pkg;
    localparam int PACKET_LENGTH = 8;
    localparam int W = 4;
    localparam int BEATS_PER_LINE = 4;
    localparam int OUTBUF_MEM_ADDR_W = 8;
    localparam int BEAT_W = W * PACKET_LENGTH;
    localparam int OUTBUF_MEM_DATA_W = BEATS_PER_LINE * BEAT_W;
    localparam int CNT_W = $clog2(BEATS_PER_LINE);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} outbuf_state_t;
endpackage

// File: rtl/outbuf_cntl_if.sv
// outbuf_cntl_if: controller, engine and memory-write signals of the output buffer controller
interface outbuf_cntl_if;
    import outbuf_cntl_pkg::*;
    logic                          eng_rstn;
    logic                          cntrl_outbuf_start;
    logic [OUTBUF_MEM_ADDR_W-1:0]  cntrl_outbuf_base_addr;
    logic [BEAT_W-1:0]             eng_outbuf_din;
    logic                          eng_outbuf_din_val;
    logic                          eng_outbuf_last;
    logic                          outbuf_eng_ready;
    logic                          outbuf_mem_wr_req;
    logic [OUTBUF_MEM_ADDR_W-1:0]  outbuf_mem_wr_addr;
    logic [OUTBUF_MEM_DATA_W-1:0]  outbuf_mem_wr_data;
    logic                          outbuf_mem_wr_ack;
    logic [OUTBUF_MEM_ADDR_W:0]    outbuf_cntl_lines_written;
    logic                          outbuf_cntl_done;
    modport slave (
        input  eng_rstn, cntrl_outbuf_start, cntrl_outbuf_base_addr, eng_outbuf_din,
               eng_outbuf_din_val, eng_outbuf_last, outbuf_mem_wr_ack,
        output outbuf_eng_ready, outbuf_mem_wr_req, outbuf_mem_wr_addr, outbuf_mem_wr_data,
               outbuf_cntl_lines_written, outbuf_cntl_done
    );
    modport master (
        output eng_rstn, cntrl_outbuf_start, cntrl_outbuf_base_addr, eng_outbuf_din,
               eng_outbuf_din_val, eng_outbuf_last, outbuf_mem_wr_ack,
        input  outbuf_eng_ready, outbuf_mem_wr_req, outbuf_mem_wr_addr, outbuf_mem_wr_data,
               outbuf_cntl_lines_written, outbuf_cntl_done
    );
endinterface

// File: rtl/outbuf_line_pingpong.sv
// outbuf_line_pingpong: two-entry line buffer; beats fill one line while the other drains
module outbuf_line_pingpong
    import outbuf_cntl_pkg::*;
(
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         clear,
    input  logic [BEAT_W-1:0]            beat,
    input  logic                         val,
    input  logic                         last,
    output logic [OUTBUF_MEM_DATA_W-1:0] line,
    output logic                         full,
    output logic                         fill_full,
    output logic                         empty,
    input  logic                         free
);
    logic [OUTBUF_MEM_DATA_W-1:0] lines [2];
    logic [1:0]                   full_q;
    logic                         fill_ptr, drain_ptr;
    logic [CNT_W-1:0]             beat_cnt;
    logic                         line_done;
    assign line_done = val & (last | beat_cnt == CNT_W'(BEATS_PER_LINE - 1));
    // val only arrives for a non-full fill line and free only for a full drain line,
    // so both updates always target different entries
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lines <= '{default: '0};
            full_q <= '0;
            fill_ptr <= 1'b0;
            drain_ptr <= 1'b0;
            beat_cnt <= '0;
        end else if (clear) begin
            lines <= '{default: '0};
            full_q <= '0;
            fill_ptr <= 1'b0;
            drain_ptr <= 1'b0;
            beat_cnt <= '0;
        end else begin
            if (val) begin
                lines[fill_ptr][beat_cnt*BEAT_W +: BEAT_W] <= beat;
                beat_cnt <= line_done ? '0 : beat_cnt + 1'b1;
            end
            if (line_done) begin
                full_q[fill_ptr] <= 1'b1;
                fill_ptr <= ~fill_ptr;
            end
            if (free) begin
                full_q[drain_ptr] <= 1'b0;
                lines[drain_ptr] <= '0;
                drain_ptr <= ~drain_ptr;
            end
        end
    end
    assign line = lines[drain_ptr];
    assign full = full_q[drain_ptr];
    assign fill_full = full_q[fill_ptr];
    assign empty = ~|full_q;
endmodule

// File: rtl/outbuf_cntl.sv
// outbuf_cntl: packs engine beats into lines and writes them to consecutive output memory addresses
module outbuf_cntl
    import outbuf_cntl_pkg::*;
(
    input  logic          clk,
    input  logic          rstn,
    outbuf_cntl_if.slave  bus
);
    outbuf_state_t                state, next_state;
    logic [OUTBUF_MEM_ADDR_W-1:0] wr_ptr;
    logic [OUTBUF_MEM_ADDR_W:0]   lines_written;
    logic                         clear, accept, free, drain_full, fill_full, empty;
    assign clear = ~bus.eng_rstn;
    assign accept = bus.eng_outbuf_din_val & bus.outbuf_eng_ready;
    assign free = drain_full & bus.outbuf_mem_wr_ack;
    outbuf_line_pingpong u_pp (
        .clk(clk), .rstn(rstn), .clear(clear),
        .beat(bus.eng_outbuf_din), .val(accept), .last(bus.eng_outbuf_last),
        .line(bus.outbuf_mem_wr_data), .full(drain_full), .fill_full(fill_full),
        .empty(empty), .free(free)
    );
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state <= IDLE;
        else
            state <= clear ? IDLE : next_state;
    end
    always_comb begin
        next_state = state == IDLE  ? (bus.cntrl_outbuf_start ? RUN : IDLE) :
                     state == RUN   ? (accept & bus.eng_outbuf_last ? DRAIN : RUN) :
                     state == DRAIN ? (empty ? DONE : DRAIN) : IDLE;
    end
    always_comb begin
        bus.outbuf_eng_ready = state == RUN & ~fill_full;
        bus.outbuf_cntl_done = state == DONE;
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            lines_written <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            lines_written <= '0;
        end else if (state == IDLE && bus.cntrl_outbuf_start) begin
            wr_ptr <= bus.cntrl_outbuf_base_addr;
            lines_written <= '0;
        end else if (free) begin
            wr_ptr <= wr_ptr + 1'b1;
            lines_written <= lines_written + 1'b1;
        end
    end
    assign bus.outbuf_mem_wr_req = drain_full;
    assign bus.outbuf_mem_wr_addr = wr_ptr;
    assign bus.outbuf_cntl_lines_written = lines_written;
endmodule

// File: tb/tb_outbuf_cntl.sv
// tb_outbuf_cntl: directed vector table plus hand-written job sequences for outbuf_cntl
module tb_outbuf_cntl;
    import outbuf_cntl_pkg::*;
    logic clk = 1'b0, rstn = 1'b0;
    int nchk = 0, nerr = 0;
    int nw, ndone;
    logic [7:0]   wa [8];
    logic [127:0] wd [8];
    outbuf_cntl_if bus();
    outbuf_cntl dut (.clk(clk), .rstn(rstn), .bus(bus));
    always #5 clk = ~clk;

    typedef struct {
        logic start; logic [7:0] base; logic val; logic [31:0] din; logic last; logic ack;
        logic ready; logic req; logic [7:0] addr; logic [127:0] data; logic [8:0] lw; logic done;
    } vec_t;
    vec_t v [20];

    function automatic logic [127:0] line4(input logic [31:0] a, b, c, d);
        return {d, c, b, a};
    endfunction
    function automatic vec_t mk(input logic s, input logic [7:0] b, input logic vl, input logic [31:0] di,
                                input logic ls, input logic ak, input logic rd, input logic rq,
                                input logic [7:0] ad, input logic [127:0] da, input logic [8:0] l, input logic dn);
        vec_t r;
        r.start = s; r.base = b; r.val = vl; r.din = di; r.last = ls; r.ack = ak;
        r.ready = rd; r.req = rq; r.addr = ad; r.data = da; r.lw = l; r.done = dn;
        return r;
    endfunction
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic observe();
        if (bus.outbuf_mem_wr_req && bus.outbuf_mem_wr_ack && nw < 8) begin
            wa[nw] = bus.outbuf_mem_wr_addr;
            wd[nw] = bus.outbuf_mem_wr_data;
            nw++;
        end
        if (bus.outbuf_cntl_done) ndone++;
    endtask
    // Full job with ack tied high; beats are 1..n, optional stray start during RUN
    task automatic run_job(input logic [7:0] base, input int n, input bit inj);
        int sent = 0, cyc = 0;
        nw = 0; ndone = 0;
        bus.outbuf_mem_wr_ack = 1'b1;
        bus.cntrl_outbuf_start = 1'b1; bus.cntrl_outbuf_base_addr = base;
        observe(); tick();
        while (cyc < 200 && ndone == 0) begin
            bus.cntrl_outbuf_start = inj && cyc == 2;
            bus.cntrl_outbuf_base_addr = inj ? 8'h40 : base;
            bus.eng_outbuf_din_val = sent < n;
            bus.eng_outbuf_din = 32'(sent + 1);
            bus.eng_outbuf_last = sent == n - 1;
            if (bus.eng_outbuf_din_val && bus.outbuf_eng_ready) sent++;
            observe(); tick(); cyc++;
        end
        chk("job_done_seen", 128'(ndone != 0), 128'd1);
        bus.cntrl_outbuf_start = 1'b0; bus.eng_outbuf_din_val = 1'b0; bus.eng_outbuf_last = 1'b0;
        for (int k = 0; k < 3; k++) begin observe(); tick(); end
    endtask

    initial begin
        int acc, bad;
        bus.eng_rstn = 1'b1; bus.cntrl_outbuf_start = 1'b0; bus.cntrl_outbuf_base_addr = '0;
        bus.eng_outbuf_din = '0; bus.eng_outbuf_din_val = 1'b0; bus.eng_outbuf_last = 1'b0;
        bus.outbuf_mem_wr_ack = 1'b0;
        #1;
        chk("rst_ready", 128'(bus.outbuf_eng_ready), 0);
        chk("rst_req", 128'(bus.outbuf_mem_wr_req), 0);
        chk("rst_addr", 128'(bus.outbuf_mem_wr_addr), 0);
        chk("rst_data", bus.outbuf_mem_wr_data, 0);
        chk("rst_lw", 128'(bus.outbuf_cntl_lines_written), 0);
        chk("rst_done", 128'(bus.outbuf_cntl_done), 0);
        tick(); tick();
        rstn = 1'b1;

        // Basic job at 0x10 then partial line at 0x20, ack tied high
        v[0]  = mk(1, 8'h10, 0, 0,     0, 1, 0, 0, 8'h00, 0, 0, 0);
        v[1]  = mk(0, 8'h10, 1, 1,     0, 1, 1, 0, 8'h10, 0, 0, 0);
        v[2]  = mk(0, 8'h10, 1, 2,     0, 1, 1, 0, 8'h10, 0, 0, 0);
        v[3]  = mk(0, 8'h10, 1, 3,     0, 1, 1, 0, 8'h10, 0, 0, 0);
        v[4]  = mk(0, 8'h10, 1, 4,     0, 1, 1, 0, 8'h10, 0, 0, 0);
        v[5]  = mk(0, 8'h10, 1, 5,     0, 1, 1, 1, 8'h10, line4(1, 2, 3, 4), 0, 0);
        v[6]  = mk(0, 8'h10, 1, 6,     0, 1, 1, 0, 8'h11, 0, 1, 0);
        v[7]  = mk(0, 8'h10, 1, 7,     0, 1, 1, 0, 8'h11, 0, 1, 0);
        v[8]  = mk(0, 8'h10, 1, 8,     1, 1, 1, 0, 8'h11, 0, 1, 0);
        v[9]  = mk(0, 8'h10, 0, 0,     0, 1, 0, 1, 8'h11, line4(5, 6, 7, 8), 1, 0);
        v[10] = mk(0, 8'h10, 0, 0,     0, 1, 0, 0, 8'h12, 0, 2, 0);
        v[11] = mk(0, 8'h10, 0, 0,     0, 1, 0, 0, 8'h12, 0, 2, 1);
        v[12] = mk(0, 8'h10, 0, 0,     0, 1, 0, 0, 8'h12, 0, 2, 0);
        v[13] = mk(1, 8'h20, 0, 0,     0, 1, 0, 0, 8'h12, 0, 2, 0);
        v[14] = mk(0, 8'h20, 1, 32'hA, 0, 1, 1, 0, 8'h20, 0, 0, 0);
        v[15] = mk(0, 8'h20, 1, 32'hB, 1, 1, 1, 0, 8'h20, 0, 0, 0);
        v[16] = mk(0, 8'h20, 0, 0,     0, 1, 0, 1, 8'h20, line4(32'hA, 32'hB, 0, 0), 0, 0);
        v[17] = mk(0, 8'h20, 0, 0,     0, 1, 0, 0, 8'h21, 0, 1, 0);
        v[18] = mk(0, 8'h20, 0, 0,     0, 1, 0, 0, 8'h21, 0, 1, 1);
        v[19] = mk(0, 8'h20, 0, 0,     0, 1, 0, 0, 8'h21, 0, 1, 0);
        for (int k = 0; k < 20; k++) begin
            bus.cntrl_outbuf_start = v[k].start; bus.cntrl_outbuf_base_addr = v[k].base;
            bus.eng_outbuf_din_val = v[k].val; bus.eng_outbuf_din = v[k].din;
            bus.eng_outbuf_last = v[k].last; bus.outbuf_mem_wr_ack = v[k].ack;
            chk($sformatf("v%0d_ready", k), 128'(bus.outbuf_eng_ready), 128'(v[k].ready));
            chk($sformatf("v%0d_req", k), 128'(bus.outbuf_mem_wr_req), 128'(v[k].req));
            chk($sformatf("v%0d_addr", k), 128'(bus.outbuf_mem_wr_addr), 128'(v[k].addr));
            if (v[k].req) chk($sformatf("v%0d_data", k), bus.outbuf_mem_wr_data, v[k].data);
            chk($sformatf("v%0d_lw", k), 128'(bus.outbuf_cntl_lines_written), 128'(v[k].lw));
            chk($sformatf("v%0d_done", k), 128'(bus.outbuf_cntl_done), 128'(v[k].done));
            tick();
        end
        bus.cntrl_outbuf_start = 1'b0; bus.eng_outbuf_din_val = 1'b0; bus.eng_outbuf_last = 1'b0;

        // Backpressure: ack low, two lines fill then ready drops
        bus.outbuf_mem_wr_ack = 1'b0;
        bus.cntrl_outbuf_start = 1'b1; bus.cntrl_outbuf_base_addr = 8'h30;
        tick();
        bus.cntrl_outbuf_start = 1'b0;
        acc = 0;
        for (int k = 0; k < 12; k++) begin
            bus.eng_outbuf_din_val = 1'b1; bus.eng_outbuf_din = 32'(acc + 1);
            if (bus.outbuf_eng_ready) acc++;
            tick();
        end
        bus.eng_outbuf_din_val = 1'b0;
        chk("bp_accepted", 128'(acc), 128'd8);
        chk("bp_ready_low", 128'(bus.outbuf_eng_ready), 0);
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.outbuf_mem_wr_req !== 1'b1 || bus.outbuf_mem_wr_addr !== 8'h30 ||
                bus.outbuf_mem_wr_data !== line4(1, 2, 3, 4)) bad++;
            tick();
        end
        chk("bp_stable_cycles_bad", 128'(bad), 0);
        bus.outbuf_mem_wr_ack = 1'b1;
        chk("bp_w0_req", 128'(bus.outbuf_mem_wr_req), 1);
        chk("bp_w0_addr", 128'(bus.outbuf_mem_wr_addr), 128'h30);
        tick();
        chk("bp_w1_req", 128'(bus.outbuf_mem_wr_req), 1);
        chk("bp_w1_addr", 128'(bus.outbuf_mem_wr_addr), 128'h31);
        chk("bp_w1_data", bus.outbuf_mem_wr_data, line4(5, 6, 7, 8));
        chk("bp_ready_back", 128'(bus.outbuf_eng_ready), 1);
        tick();
        chk("bp_req_off", 128'(bus.outbuf_mem_wr_req), 0);
        chk("bp_lw2", 128'(bus.outbuf_cntl_lines_written), 2);
        bus.eng_outbuf_din_val = 1'b1; bus.eng_outbuf_din = 32'h9; bus.eng_outbuf_last = 1'b1;
        tick();
        bus.eng_outbuf_din_val = 1'b0; bus.eng_outbuf_last = 1'b0;
        ndone = 0;
        for (int k = 0; k < 10 && ndone == 0; k++) begin
            if (bus.outbuf_cntl_done) ndone++;
            tick();
        end
        chk("bp_done", 128'(ndone), 1);
        chk("bp_lw3", 128'(bus.outbuf_cntl_lines_written), 3);

        // Soft reset while a write is pending
        bus.outbuf_mem_wr_ack = 1'b0;
        bus.cntrl_outbuf_start = 1'b1; bus.cntrl_outbuf_base_addr = 8'h50;
        tick();
        bus.cntrl_outbuf_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.eng_outbuf_din_val = 1'b1; bus.eng_outbuf_din = 32'(k + 1);
            tick();
        end
        bus.eng_outbuf_din_val = 1'b0;
        chk("sr_req_before", 128'(bus.outbuf_mem_wr_req), 1);
        chk("sr_addr_before", 128'(bus.outbuf_mem_wr_addr), 128'h50);
        bus.eng_rstn = 1'b0;
        tick();
        bus.eng_rstn = 1'b1;
        chk("sr_req", 128'(bus.outbuf_mem_wr_req), 0);
        chk("sr_ready", 128'(bus.outbuf_eng_ready), 0);
        chk("sr_lw", 128'(bus.outbuf_cntl_lines_written), 0);
        chk("sr_addr", 128'(bus.outbuf_mem_wr_addr), 0);
        chk("sr_data", bus.outbuf_mem_wr_data, 0);
        tick();
        chk("sr_idle_ready", 128'(bus.outbuf_eng_ready), 0);
        run_job(8'h60, 4, 1'b0);
        chk("sr_job_writes", 128'(nw), 1);
        chk("sr_job_addr", 128'(wa[0]), 128'h60);
        chk("sr_job_data", wd[0], line4(1, 2, 3, 4));
        chk("sr_job_done", 128'(ndone), 1);
        chk("sr_job_lw", 128'(bus.outbuf_cntl_lines_written), 1);

        // Address wrap from 0xFF
        run_job(8'hFF, 12, 1'b0);
        chk("wrap_writes", 128'(nw), 3);
        chk("wrap_a0", 128'(wa[0]), 128'hFF);
        chk("wrap_a1", 128'(wa[1]), 128'h00);
        chk("wrap_a2", 128'(wa[2]), 128'h01);
        chk("wrap_d2", wd[2], line4(9, 10, 11, 12));
        chk("wrap_done", 128'(ndone), 1);
        chk("wrap_lw", 128'(bus.outbuf_cntl_lines_written), 3);

        // Start during RUN is ignored
        run_job(8'h70, 8, 1'b1);
        chk("ign_writes", 128'(nw), 2);
        chk("ign_a0", 128'(wa[0]), 128'h70);
        chk("ign_a1", 128'(wa[1]), 128'h71);
        chk("ign_d1", wd[1], line4(5, 6, 7, 8));
        chk("ign_done", 128'(ndone), 1);
        chk("ign_lw", 128'(bus.outbuf_cntl_lines_written), 2);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
